multwrap_ctrl: RTL and testbench

Sequencer directly upstream of the weight-BRAM/multi-matmul wrapper. On a start pulse it runs one full projection pass: for each output group it clears the accumulators, streams K_STEPS weight reads from the weight BRAM with matching activation-buffer reads, waits for the accumulation-done flag and hands the result off downstream under a valid/ready handshake. It owns every control input of the wrapper (`en_module`, `internal_rst_n`, `internal_reset_acc`, `w_mat_enb`, `w_mat_addrb`) and the read port of the activation buffer feeding `in_multi_matmul`.

---
 rtl/linear_proj_pkg.sv | 24 ++
 rtl/multwrap_ctrl.sv | 162 ++++++++++++++++
 tb/tb_multwrap_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/linear_proj_pkg.sv
// Shared types and default sizing for the linear-projection datapath.
// K_STEPS/N_GROUPS defaults fall out of the matrix and core dimensions.
package linear_proj_pkg;

  localparam int INNER_DIMENSION   = 64;
  localparam int B_OUTER_DIMENSION = 96;
  localparam int BLOCK_SIZE        = 16;
  localparam int NUM_CORES_B       = 2;
  localparam int TOTAL_MODULES     = 1;

  // Inner-dimension chunks per accumulation, and output column groups per pass.
  localparam int DEF_K_STEPS  = INNER_DIMENSION / BLOCK_SIZE;
  localparam int DEF_N_GROUPS = B_OUTER_DIMENSION / (BLOCK_SIZE * NUM_CORES_B * TOTAL_MODULES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_FETCH,
    ST_WAIT_ACC,
    ST_OUT,
    ST_DONE
  } mwc_state_t;

endpackage

// File: rtl/multwrap_ctrl.sv
// Pass sequencer for the weight-BRAM / multi-matmul wrapper: clears, streams
// weight + activation reads per group, waits for accumulation, hands off results.
module multwrap_ctrl
  import linear_proj_pkg::*;
#(
  parameter int K_STEPS      = DEF_K_STEPS,
  parameter int N_GROUPS     = DEF_N_GROUPS,
  parameter int ADDR_WIDTH_B = (K_STEPS * N_GROUPS > 1) ? $clog2(K_STEPS * N_GROUPS) : 1,
  parameter int ADDR_WIDTH_A = (K_STEPS > 1) ? $clog2(K_STEPS) : 1,
  parameter int GROUP_WIDTH  = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    acc_done_wrap,
  input  logic                    out_ready,
  output logic                    w_mat_enb,
  output logic [ADDR_WIDTH_B-1:0] w_mat_addrb,
  output logic                    act_enb,
  output logic [ADDR_WIDTH_A-1:0] act_addr,
  output logic                    en_module,
  output logic                    internal_rst_n,
  output logic                    internal_reset_acc,
  output logic                    out_valid,
  output logic [GROUP_WIDTH-1:0]  group_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    err_early
);

  localparam logic [ADDR_WIDTH_A-1:0] K_LAST    = ADDR_WIDTH_A'(K_STEPS - 1);
  localparam logic [GROUP_WIDTH-1:0]  G_LAST    = GROUP_WIDTH'(N_GROUPS - 1);
  localparam logic [ADDR_WIDTH_B-1:0] K_STEPS_B = ADDR_WIDTH_B'(K_STEPS);

  mwc_state_t              state_q, state_d;
  logic [ADDR_WIDTH_A-1:0] k_q, k_d;
  logic [GROUP_WIDTH-1:0]  group_q, group_d;
  logic                    err_early_q, err_early_d;

  logic                    w_mat_enb_q, w_mat_enb_d;
  logic [ADDR_WIDTH_B-1:0] w_mat_addrb_q, w_mat_addrb_d;
  logic                    act_enb_q, act_enb_d;
  logic [ADDR_WIDTH_A-1:0] act_addr_q, act_addr_d;
  logic                    en_module_q, en_module_d;
  logic                    internal_rst_n_q, internal_rst_n_d;
  logic                    internal_reset_acc_q, internal_reset_acc_d;
  logic                    out_valid_q, out_valid_d;
  logic [GROUP_WIDTH-1:0]  group_idx_q, group_idx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    group_d     = group_q;
    err_early_d = err_early_q;

    if (acc_done_wrap && (state_q != ST_WAIT_ACC)) err_early_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_CLR;
          group_d     = '0;
          err_early_d = 1'b0;
        end
      end
      ST_CLR: begin
        k_d     = '0;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (k_q == K_LAST) state_d = ST_WAIT_ACC;
        else               k_d     = k_q + 1'b1;
      end
      ST_WAIT_ACC: begin
        if (acc_done_wrap) state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          if (group_q == G_LAST) begin
            state_d = ST_DONE;
          end else begin
            group_d = group_q + 1'b1;
            state_d = ST_CLR;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear in the same cycle as the state they describe.
  always_comb begin
    w_mat_enb_d          = (state_d == ST_FETCH);
    act_enb_d            = (state_d == ST_FETCH);
    w_mat_addrb_d        = w_mat_addrb_q;
    act_addr_d           = act_addr_q;
    if (state_d == ST_FETCH) begin
      w_mat_addrb_d = ADDR_WIDTH_B'(group_d) * K_STEPS_B + ADDR_WIDTH_B'(k_d);
      act_addr_d    = k_d;
    end
    en_module_d          = w_mat_enb_q;
    internal_rst_n_d     = !((state_d == ST_CLR) && (group_d == '0));
    internal_reset_acc_d = (state_d == ST_CLR);
    out_valid_d          = (state_d == ST_OUT);
    group_idx_d          = group_d;
    busy_d               = (state_d != ST_IDLE);
    done_d               = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= ST_IDLE;
      k_q                  <= '0;
      group_q              <= '0;
      err_early_q          <= 1'b0;
      w_mat_enb_q          <= 1'b0;
      w_mat_addrb_q        <= '0;
      act_enb_q            <= 1'b0;
      act_addr_q           <= '0;
      en_module_q          <= 1'b0;
      internal_rst_n_q     <= 1'b0;
      internal_reset_acc_q <= 1'b0;
      out_valid_q          <= 1'b0;
      group_idx_q          <= '0;
      busy_q               <= 1'b0;
      done_q               <= 1'b0;
    end else begin
      state_q              <= state_d;
      k_q                  <= k_d;
      group_q              <= group_d;
      err_early_q          <= err_early_d;
      w_mat_enb_q          <= w_mat_enb_d;
      w_mat_addrb_q        <= w_mat_addrb_d;
      act_enb_q            <= act_enb_d;
      act_addr_q           <= act_addr_d;
      en_module_q          <= en_module_d;
      internal_rst_n_q     <= internal_rst_n_d;
      internal_reset_acc_q <= internal_reset_acc_d;
      out_valid_q          <= out_valid_d;
      group_idx_q          <= group_idx_d;
      busy_q               <= busy_d;
      done_q               <= done_d;
    end
  end

  assign w_mat_enb          = w_mat_enb_q;
  assign w_mat_addrb        = w_mat_addrb_q;
  assign act_enb            = act_enb_q;
  assign act_addr           = act_addr_q;
  assign en_module          = en_module_q;
  assign internal_rst_n     = internal_rst_n_q;
  assign internal_reset_acc = internal_reset_acc_q;
  assign out_valid          = out_valid_q;
  assign group_idx          = group_idx_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign err_early          = err_early_q;

endmodule

// File: tb/tb_multwrap_ctrl.sv
// Scoreboard bench for multwrap_ctrl: directed passes push expected reads/groups/done,
// a wrapper responder drives acc_done/out_ready, and a monitor pops and compares.
module tb_multwrap_ctrl;

  localparam int K = 4;
  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       acc_done_wrap = 1'b0;
  logic       out_ready = 1'b1;
  logic       w_mat_enb;
  logic [3:0] w_mat_addrb;
  logic       act_enb;
  logic [1:0] act_addr;
  logic       en_module;
  logic       internal_rst_n;
  logic       internal_reset_acc;
  logic       out_valid;
  logic [1:0] group_idx;
  logic       busy;
  logic       done;
  logic       err_early;

  int total = 0;
  int bad   = 0;

  int exp_waddr[$];
  int exp_aaddr[$];
  int exp_grp[$];
  int exp_done[$];

  int cfg_acc_delay = 0;
  int cfg_bp_cycles = 0;
  bit cfg_early     = 1'b0;

  multwrap_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .acc_done_wrap      (acc_done_wrap),
    .out_ready          (out_ready),
    .w_mat_enb          (w_mat_enb),
    .w_mat_addrb        (w_mat_addrb),
    .act_enb            (act_enb),
    .act_addr           (act_addr),
    .en_module          (en_module),
    .internal_rst_n     (internal_rst_n),
    .internal_reset_acc (internal_reset_acc),
    .out_valid          (out_valid),
    .group_idx          (group_idx),
    .busy               (busy),
    .done               (done),
    .err_early          (err_early)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_w_mat_enb"}, w_mat_enb, 0);
    check_output({tag, "_w_mat_addrb"}, w_mat_addrb, 0);
    check_output({tag, "_act_enb"}, act_enb, 0);
    check_output({tag, "_act_addr"}, act_addr, 0);
    check_output({tag, "_en_module"}, en_module, 0);
    check_output({tag, "_internal_rst_n"}, internal_rst_n, 0);
    check_output({tag, "_internal_reset_acc"}, internal_reset_acc, 0);
    check_output({tag, "_out_valid"}, out_valid, 0);
    check_output({tag, "_group_idx"}, group_idx, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_done"}, done, 0);
    check_output({tag, "_err_early"}, err_early, 0);
  endtask

  task automatic flush_expectations();
    exp_waddr.delete();
    exp_aaddr.delete();
    exp_grp.delete();
    exp_done.delete();
  endtask

  // Wrapper stand-in: acc_done a fixed delay after the read burst ends, optional early pulse, backpressure on group 1.
  initial begin
    int  cnt = -1;
    int  bp_left = 0;
    int  rd_in_pass = 0;
    bit  prev_enb = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        acc_done_wrap = 1'b0;
        out_ready     = 1'b1;
        cnt           = -1;
        prev_enb      = 1'b0;
      end else begin
        if (start && !busy) begin
          bp_left    = cfg_bp_cycles;
          rd_in_pass = 0;
        end
        acc_done_wrap = 1'b0;
        if (prev_enb && !w_mat_enb) cnt = cfg_acc_delay;
        if (cnt == 0) begin
          acc_done_wrap = 1'b1;
          cnt = -1;
        end else if (cnt > 0) begin
          cnt--;
        end
        if (cfg_early && w_mat_enb && rd_in_pass == 1) acc_done_wrap = 1'b1;
        if (w_mat_enb) rd_in_pass++;
        if (out_valid && group_idx == 2'd1 && bp_left > 0) begin
          out_ready = 1'b0;
          bp_left--;
        end else begin
          out_ready = 1'b1;
        end
        prev_enb = w_mat_enb;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT issues a read, hands off a group, or signals done.
  initial begin
    bit pe = 1'b0;
    int w;
    int a;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        pe = 1'b0;
      end else begin
        if (w_mat_enb) begin
          if (exp_waddr.size() == 0) begin
            check_output("unexpected_read", w_mat_enb, 0);
          end else begin
            w = exp_waddr.pop_front();
            a = exp_aaddr.pop_front();
            check_output("w_mat_addrb", w_mat_addrb, w);
            check_output("act_addr", act_addr, a);
            check_output("act_enb", act_enb, 1);
          end
        end
        if (w_mat_enb || en_module || pe) check_output("en_module_lag", en_module, pe);
        if (out_valid) check_output("no_read_during_out", w_mat_enb, 0);
        if (out_valid && out_ready) begin
          if (exp_grp.size() == 0) check_output("unexpected_out", out_valid, 0);
          else                     check_output("group_idx", group_idx, exp_grp.pop_front());
        end
        if (done) begin
          if (exp_done.size() == 0) begin
            check_output("unexpected_done", done, 0);
          end else begin
            void'(exp_done.pop_front());
            check_output("reads_left_at_done", exp_waddr.size(), 0);
            check_output("groups_left_at_done", exp_grp.size(), 0);
          end
        end
        pe = w_mat_enb;
      end
    end
  end

  task automatic apply_stimulus(input string tag, input int acc_delay, input int bp_cycles,
                                input bit early, input bit extra_starts, input int abort_at,
                                input int exp_len, input int exp_bp_len, input int exp_err);
    int n;
    int done_at;
    int bp_seen;
    cfg_acc_delay = acc_delay;
    cfg_bp_cycles = bp_cycles;
    cfg_early     = early;
    for (int g = 0; g < N; g++) begin
      for (int k = 0; k < K; k++) begin
        exp_waddr.push_back(g * K + k);
        exp_aaddr.push_back(k);
      end
      exp_grp.push_back(g);
    end
    exp_done.push_back(1);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    done_at = 0;
    bp_seen = 0;
    check_output({tag, "_clr_err_early"}, err_early, 0);
    check_output({tag, "_clr_busy"}, busy, 1);
    check_output({tag, "_clr_internal_rst_n"}, internal_rst_n, 0);
    check_output({tag, "_clr_reset_acc"}, internal_reset_acc, 1);

    while (done_at == 0 && n < 400) begin
      if (done) done_at = n;
      if (out_valid && group_idx == 2'd1) bp_seen++;
      start = (extra_starts && (n == 5 || n == 15)) ? 1'b1 : 1'b0;
      if (abort_at != 0 && n == abort_at) begin
        #3 rst_n = 1'b0;
        #1 check_reset_outputs({tag, "_async"});
        flush_expectations();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (done_at == 0) begin
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;

    check_output({tag, "_pass_len"}, done_at, exp_len);
    if (done_at == 0) flush_expectations();
    check_output({tag, "_bp_cycles"}, bp_seen, exp_bp_len);
    check_output({tag, "_err_early"}, err_early, exp_err);
    @(negedge clk);
    check_output({tag, "_idle_busy"}, busy, 0);
    check_output({tag, "_idle_internal_rst_n"}, internal_rst_n, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #4 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("release_internal_rst_n", internal_rst_n, 0);
    @(negedge clk);
    check_output("idle_internal_rst_n", internal_rst_n, 1);
    check_output("idle_busy", busy, 0);
    repeat (2) @(negedge clk);

    // tag, acc_delay, bp, early, extra_starts, abort_at, exp_len, exp_bp_len, exp_err
    apply_stimulus("basic",     2, 0, 1'b0, 1'b0, 0,  28, 1, 0);
    apply_stimulus("minlat",    0, 0, 1'b0, 1'b0, 0,  22, 1, 0);
    apply_stimulus("backpress", 0, 5, 1'b0, 1'b0, 0,  27, 6, 0);
    apply_stimulus("early",     0, 0, 1'b1, 1'b0, 0,  22, 1, 1);
    apply_stimulus("busystart", 0, 0, 1'b0, 1'b1, 0,  22, 1, 0);
    apply_stimulus("abort",     0, 0, 1'b0, 1'b0, 10, 0,  0, 0);
    repeat (2) @(negedge clk);
    apply_stimulus("after_rst", 1, 0, 1'b0, 1'b0, 0,  25, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
